// File: rtl/arc_pkg.sv
// Shared execute-stage definitions for the multiply/divide unit.
// Holds the R-type funct codes it decodes, the AluOp class that enables it,
// the FSM state type, and a helper that flags the HI/LO family of functs.
package arc_pkg;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MTHI  = 6'd17;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MTLO  = 6'd19;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} muldiv_state_t;

  // True for every funct this unit owns (HI/LO moves and mul/div).
  function automatic logic is_muldiv(input logic [5:0] fn);
    return fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                      FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  endfunction
endpackage

// File: rtl/e_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_start          load operands and begin (DW iterations follow)
//   i_dividend       unsigned dividend
//   i_divisor        unsigned divisor (0 yields all-ones quotient)
//   o_done           high during the final iteration cycle
//   o_quotient       quotient, valid the cycle after o_done
//   o_remainder      remainder, valid the cycle after o_done
module e_div_core #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_dividend,
  input  logic [DW-1:0] i_divisor,
  output logic          o_done,
  output logic [DW-1:0] o_quotient,
  output logic [DW-1:0] o_remainder
);
  logic             r_run;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_quo, r_rem, r_dvs;
  logic [DW:0]      w_shift;
  logic             w_ge;
  logic [DW-1:0]    w_diff;

  // Partial remainder shifted left with the next dividend bit brought in.
  // When it is >= divisor the true difference is below 2**DW, so the
  // low DW bits of the modular subtraction are exact.
  assign w_shift = {r_rem, r_quo[DW-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvs};
  assign w_diff  = w_shift[DW-1:0] - r_dvs;
  assign o_done  = r_run && (r_cnt == CNT_W'(DW-1));

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
    end else if (r_run) begin
      // Quotient register doubles as the dividend shift register.
      r_quo <= {r_quo[DW-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_shift[DW-1:0];
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end
endmodule

// File: rtl/e_muldiv.sv
// Execute-stage multi-cycle multiply/divide unit; owns architectural HI/LO.
// Serves MFHI/MFLO/MTHI/MTLO and runs MULT/MULTU/DIV/DIVU iteratively.
// Build option: MULDIV_FAST_MUL_EN -> single-cycle DW x DW multiplier
//   (MUL state skipped, HI/LO written one cycle after accept).
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_con_Valid       execute instruction valid
//   i_con_Flush       squash execute instruction this cycle
//   i_con_AluOp       AluOp; only [1:0]==R-type is acted on
//   i_con_FuncCode    R-type funct
//   i_dat_Rs/Rt       operands
//   o_con_Stall       hold IF/ID/EX (dependent op while busy)
//   o_con_Busy        mul/div in flight
//   o_dat_Result      MFHI/MFLO read data, 0 otherwise
module e_muldiv import arc_pkg::*; #(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_con_Valid,
  input  logic          i_con_Flush,
  input  logic [5:0]    i_con_AluOp,
  input  logic [5:0]    i_con_FuncCode,
  input  logic [DW-1:0] i_dat_Rs,
  input  logic [DW-1:0] i_dat_Rt,
  output logic          o_con_Stall,
  output logic          o_con_Busy,
  output logic [DW-1:0] o_dat_Result
);
  muldiv_state_t    r_state, w_next;
  logic [DW-1:0]    r_hi, r_lo, r_rs_raw;
  logic [2*DW-1:0]  r_prod;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div, r_neg_pq, r_neg_r, r_div0;

  logic             w_md, w_acc, w_signed, w_sa, w_sb, w_is_mul, w_is_div;
  logic [DW-1:0]    w_mag_a, w_mag_b;
  logic             w_div_done;
  logic [DW-1:0]    w_quo, w_rem, w_quo_fix, w_rem_fix;
  logic [2*DW-1:0]  w_prod_fix;
  logic             w_unused_aluop;

  assign w_unused_aluop = ^i_con_AluOp[5:2];

  assign w_md        = (i_con_AluOp[1:0] == ALUOP_RTYPE) && is_muldiv(i_con_FuncCode);
  assign o_con_Busy  = (r_state != IDLE);
  assign o_con_Stall = o_con_Busy & i_con_Valid & w_md;
  assign w_acc       = i_con_Valid & ~i_con_Flush & w_md & ~o_con_Stall;

  assign w_is_mul = (i_con_FuncCode == FN_MULT) || (i_con_FuncCode == FN_MULTU);
  assign w_is_div = (i_con_FuncCode == FN_DIV)  || (i_con_FuncCode == FN_DIVU);
  assign w_signed = (i_con_FuncCode == FN_MULT) || (i_con_FuncCode == FN_DIV);
  assign w_sa     = w_signed & i_dat_Rs[DW-1];
  assign w_sb     = w_signed & i_dat_Rt[DW-1];
  assign w_mag_a  = w_sa ? -i_dat_Rs : i_dat_Rs;
  assign w_mag_b  = w_sb ? -i_dat_Rt : i_dat_Rt;

  always_comb begin
    o_dat_Result = '0;
    if (w_acc && i_con_FuncCode == FN_MFHI)      o_dat_Result = r_hi;
    else if (w_acc && i_con_FuncCode == FN_MFLO) o_dat_Result = r_lo;
  end

  e_div_core #(.DW(DW), .CNT_W(CNT_W)) u_div (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_acc & w_is_div),
    .i_dividend  (w_mag_a),
    .i_divisor   (w_mag_b),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_prod_fix = r_neg_pq ? -r_prod : r_prod;
  assign w_quo_fix  = r_neg_pq ? -w_quo  : w_quo;
  assign w_rem_fix  = r_neg_r  ? -w_rem  : w_rem;

`ifndef MULDIV_FAST_MUL_EN
  // Shift-add: r_prod starts as {0, multiplier}; each step conditionally
  // adds the multiplicand to the upper half and shifts right by one.
  logic [DW-1:0] r_mcand;
  logic [DW:0]   w_add;
  assign w_add = {1'b0, r_prod[2*DW-1:DW]} + {1'b0, (r_prod[0] ? r_mcand : '0)};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_acc && w_is_div) w_next = DIV;
`ifdef MULDIV_FAST_MUL_EN
        else if (w_acc && w_is_mul) w_next = FIX;
`else
        else if (w_acc && w_is_mul) w_next = MUL;
`endif
      end
      MUL:     if (r_cnt == CNT_W'(DW-1)) w_next = FIX;
      DIV:     if (w_div_done) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rs_raw <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_pq <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      r_mcand  <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_cnt <= '0;
        if (i_con_FuncCode == FN_MTHI) r_hi <= i_dat_Rs;
        if (i_con_FuncCode == FN_MTLO) r_lo <= i_dat_Rs;
        if (w_is_mul) begin
          r_is_div <= 1'b0;
          r_neg_pq <= w_sa ^ w_sb;
`ifdef MULDIV_FAST_MUL_EN
          r_prod   <= {{DW{1'b0}}, w_mag_a} * {{DW{1'b0}}, w_mag_b};
`else
          r_prod   <= {{DW{1'b0}}, w_mag_b};
          r_mcand  <= w_mag_a;
`endif
        end
        if (w_is_div) begin
          r_is_div <= 1'b1;
          r_neg_pq <= w_sa ^ w_sb;
          r_neg_r  <= w_sa;
          r_div0   <= (i_dat_Rt == '0);
          r_rs_raw <= i_dat_Rs;
        end
      end else begin
        case (r_state)
`ifndef MULDIV_FAST_MUL_EN
          MUL: begin
            r_prod <= {w_add, r_prod[DW-1:1]};
            r_cnt  <= r_cnt + 1'b1;
          end
`endif
          FIX: begin
            if (!r_is_div) begin
              r_hi <= w_prod_fix[2*DW-1:DW];
              r_lo <= w_prod_fix[DW-1:0];
            end else if (r_div0) begin
              // Divide by zero: no trap, dividend passes through to HI.
              r_hi <= r_rs_raw;
              r_lo <= '1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
